// File: rtl/caf_peak_track_if.sv
// Bus bundle for caf_peak_track: complex product input beat and the held
// peak-result output with its downstream ready.
interface caf_peak_track_if #(
    parameter int i_bits     = 24,
    parameter int q_bits     = 24,
    parameter int index_bits = 3,
    parameter int mag_bits   = 49
);
    logic                         m_axis_product_tvalid;
    logic signed [i_bits-1:0]     i;
    logic signed [q_bits-1:0]     q;
    logic                         m_axis_peak_tready;
    logic                         s_axis_peak_tvalid;
    logic        [index_bits-1:0] peak_index;
    logic        [mag_bits-1:0]   peak_mag;
    logic                         overrun;

    modport slave (
        input  m_axis_product_tvalid, i, q, m_axis_peak_tready,
        output s_axis_peak_tvalid, peak_index, peak_mag, overrun
    );

    modport master (
        output m_axis_product_tvalid, i, q, m_axis_peak_tready,
        input  s_axis_peak_tvalid, peak_index, peak_mag, overrun
    );
endinterface

// File: rtl/caf_peak_track.sv
// Magnitude-squared peak tracker over a sweep of complex dot-product results;
// square -> sum -> compare pipeline feeding a held valid/ready result register.
module caf_peak_track #(
    parameter int i_bits       = 24,
    parameter int q_bits       = 24,
    parameter int sweep_length = 8,
    parameter int index_bits   = 3,
    parameter int mag_bits     = 49
) (
    input  logic           clk,
    input  logic           rst,
    caf_peak_track_if.slave bus
);
    localparam int STAGES = 3;
    localparam logic [index_bits-1:0] LAST_IDX = index_bits'(sweep_length - 1);

    // sample counter
    logic [index_bits-1:0] cnt_q, cnt_d;
    logic                  in_last;

    // pipeline valids and stage registers
    logic [STAGES:1]              vld_pipe_q, vld_pipe_d;
    logic signed [mag_bits-1:0]   i_ext, q_ext, ii_d, qq_d, ii_q, qq_q;
    logic [index_bits-1:0]        idx1_q, idx2_q;
    logic                         last1_q, last2_q, last3_q;
    logic [mag_bits-1:0]          mag2_q, mag2_d;

    // running max
    logic [mag_bits-1:0]   max_q, max_d;
    logic [index_bits-1:0] maxidx_q, maxidx_d;
    logic                  take;

    // output register
    logic                  tvalid_q, tvalid_d;
    logic [index_bits-1:0] pidx_q, pidx_d;
    logic [mag_bits-1:0]   pmag_q, pmag_d;
    logic                  ovr_q, ovr_d;
    logic                  load;

    assign in_last = (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d = cnt_q;
        if (bus.m_axis_product_tvalid)
            cnt_d = in_last ? '0 : cnt_q + 1'b1;
    end

    // Widen before squaring so the product lands directly in mag_bits.
    assign i_ext  = {{(mag_bits-i_bits){bus.i[i_bits-1]}}, bus.i};
    assign q_ext  = {{(mag_bits-q_bits){bus.q[q_bits-1]}}, bus.q};
    assign ii_d   = i_ext * i_ext;
    assign qq_d   = q_ext * q_ext;
    assign mag2_d = ii_q + qq_q;

    assign vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.m_axis_product_tvalid};

    // Index 0 always reloads so back-to-back sweeps never see a stale max.
    assign take = vld_pipe_q[2] && ((idx2_q == '0) || (mag2_q > max_q));

    always_comb begin
        max_d    = max_q;
        maxidx_d = maxidx_q;
        if (take) begin
            max_d    = mag2_q;
            maxidx_d = idx2_q;
        end
    end

    assign load = vld_pipe_q[3] && last3_q;

    always_comb begin
        tvalid_d = tvalid_q && !bus.m_axis_peak_tready;
        pidx_d   = pidx_q;
        pmag_d   = pmag_q;
        ovr_d    = 1'b0;
        if (load) begin
            tvalid_d = 1'b1;
            pidx_d   = maxidx_q;
            pmag_d   = max_q;
            ovr_d    = tvalid_q && !bus.m_axis_peak_tready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            ii_q       <= '0;
            qq_q       <= '0;
            idx1_q     <= '0;
            last1_q    <= 1'b0;
            mag2_q     <= '0;
            idx2_q     <= '0;
            last2_q    <= 1'b0;
            last3_q    <= 1'b0;
            max_q      <= '0;
            maxidx_q   <= '0;
            tvalid_q   <= 1'b0;
            pidx_q     <= '0;
            pmag_q     <= '0;
            ovr_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            if (bus.m_axis_product_tvalid) begin
                ii_q    <= ii_d;
                qq_q    <= qq_d;
                idx1_q  <= cnt_q;
                last1_q <= in_last;
            end
            if (vld_pipe_q[1]) begin
                mag2_q  <= mag2_d;
                idx2_q  <= idx1_q;
                last2_q <= last1_q;
            end
            last3_q    <= vld_pipe_q[2] && last2_q;
            max_q      <= max_d;
            maxidx_q   <= maxidx_d;
            tvalid_q   <= tvalid_d;
            pidx_q     <= pidx_d;
            pmag_q     <= pmag_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.s_axis_peak_tvalid = tvalid_q;
    assign bus.peak_index         = pidx_q;
    assign bus.peak_mag           = pmag_q;
    assign bus.overrun            = ovr_q;
endmodule

// File: tb/tb_caf_peak_track.sv
// Directed bench for caf_peak_track: expected peaks are queued as sweeps are
// driven and popped by a monitor whenever a result is transferred.
module tb_caf_peak_track;
    localparam int I_BITS = 12;
    localparam int Q_BITS = 12;
    localparam int SL     = 4;
    localparam int IB     = 2;
    localparam int MB     = 25;

    typedef struct packed {
        logic [IB-1:0] idx;
        logic [MB-1:0] mag;
    } peak_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    peak_t exp_q[$];
    peak_t mon_e;

    caf_peak_track_if #(.i_bits(I_BITS), .q_bits(Q_BITS), .index_bits(IB), .mag_bits(MB)) bus ();

    caf_peak_track #(
        .i_bits(I_BITS), .q_bits(Q_BITS), .sweep_length(SL),
        .index_bits(IB), .mag_bits(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int vi, input int vq);
        bus.m_axis_product_tvalid = 1'b1;
        bus.i = I_BITS'(vi);
        bus.q = Q_BITS'(vq);
        step();
        bus.m_axis_product_tvalid = 1'b0;
    endtask

    task automatic push(input int idx, input int mag);
        exp_q.push_back('{idx: IB'(idx), mag: MB'(mag)});
    endtask

    task automatic chk_out(input string tag, input int v, input int idx, input int mag, input int ovr);
        chk({tag, "_tvalid"},  64'(bus.s_axis_peak_tvalid), 64'(v));
        chk({tag, "_index"},   64'(bus.peak_index),         64'(idx));
        chk({tag, "_mag"},     64'(bus.peak_mag),           64'(mag));
        chk({tag, "_overrun"}, 64'(bus.overrun),            64'(ovr));
    endtask

    // Scoreboard side: every transfer must match the oldest queued peak.
    always @(negedge clk) begin
        if (!rst && bus.s_axis_peak_tvalid && bus.m_axis_peak_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(exp_q.size()), 64'(1));
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_index", 64'(bus.peak_index), 64'(mon_e.idx));
                chk("mon_mag",   64'(bus.peak_mag),   64'(mon_e.mag));
            end
        end
    end

    initial begin
        bus.m_axis_product_tvalid = 1'b0;
        bus.i = '0;
        bus.q = '0;
        bus.m_axis_peak_tready = 1'b1;
        repeat (3) step();
        chk_out("reset", 0, 0, 0, 0);
        #3 rst = 1'b0;
        step();

        // basic sweep plus exact latency; index 2 ties index 1 at 25
        push(1, 25);
        beat(1, 0); beat(3, 4); beat(0, -5); beat(2, 2);
        chk("lat_e0", 64'(bus.s_axis_peak_tvalid), 64'(0));
        step(); chk("lat_e1", 64'(bus.s_axis_peak_tvalid), 64'(0));
        step(); chk("lat_e2", 64'(bus.s_axis_peak_tvalid), 64'(0));
        step(); chk_out("lat_e3", 1, 1, 25, 0);
        step(); chk("lat_e4_drop", 64'(bus.s_axis_peak_tvalid), 64'(0));
        step();

        // most negative inputs at the last index
        push(3, 8388608);
        beat(0, 0); beat(0, 0); beat(0, 0); beat(-2048, -2048);
        repeat (5) step();

        // back-to-back sweeps, second one with 2-cycle bubbles
        push(0, 50);
        push(2, 49);
        beat(5, 5); beat(1, 1); beat(-6, 0); beat(0, 0);
        beat(0, 1); repeat (2) step();
        beat(0, 1); repeat (2) step();
        beat(7, 0); repeat (2) step();
        beat(0, 1);
        repeat (6) step();

        // backpressure: first result held, second overwrites with overrun
        bus.m_axis_peak_tready = 1'b0;
        beat(1, 1); beat(2, 2); beat(0, 0); beat(0, 0);
        repeat (3) step();
        chk_out("bp_first", 1, 1, 8, 0);
        push(0, 9);
        beat(0, 3); chk_out("bp_hold0", 1, 1, 8, 0);
        beat(0, 0); chk_out("bp_hold1", 1, 1, 8, 0);
        beat(0, 0); chk_out("bp_hold2", 1, 1, 8, 0);
        beat(0, 0); chk_out("bp_hold3", 1, 1, 8, 0);
        step(); chk_out("bp_hold4", 1, 1, 8, 0);
        step(); chk_out("bp_hold5", 1, 1, 8, 0);
        step(); chk_out("bp_overrun", 1, 0, 9, 1);
        step(); chk_out("bp_after", 1, 0, 9, 0);
        bus.m_axis_peak_tready = 1'b1;
        step(); chk("bp_drop", 64'(bus.s_axis_peak_tvalid), 64'(0));
        step();

        // reset mid-sweep with a held result pending
        bus.m_axis_peak_tready = 1'b0;
        beat(0, 0); beat(0, 0); beat(3, 0); beat(0, 0);
        repeat (3) step();
        chk_out("pre_rst", 1, 2, 9, 0);
        beat(100, 100); beat(100, 100);
        #3 rst = 1'b1;
        #1 chk_out("async_rst", 0, 0, 0, 0);
        repeat (2) step();
        #3 rst = 1'b0;
        bus.m_axis_peak_tready = 1'b1;
        push(1, 4);
        beat(1, 0); beat(0, 2); beat(1, 1); beat(0, 0);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        repeat (2) step();
        chk("final_idle", 64'(bus.s_axis_peak_tvalid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/caf_peak_track.md
Name: caf_peak_track

Overview:
- Downstream consumer of the complex dot-product pipeline in the CAF datapath.
- Accepts one complex dot-product result (i, q) per valid beat and computes its magnitude-squared.
- Tracks the maximum over a sweep of sweep_length consecutive results (one per lag/frequency bin).
- At sweep end, emits the peak index and magnitude on a held-valid/ready output.

Parameters:
- i_bits, 24, width of signed input i
- q_bits, 24, width of signed input q
- sweep_length, 8, results per sweep (must be >= 2)
- index_bits, 3, width of peak_index; must satisfy 2^index_bits >= sweep_length
- mag_bits, 49, width of peak_mag; must be >= max(i_bits, q_bits)*2 + 1

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- m_axis_product_tvalid  input  1  i/q valid this cycle; no backpressure upstream, every valid beat is consumed
- i  input  i_bits  signed real part of dot product
- q  input  q_bits  signed imaginary part of dot product
- m_axis_peak_tready  input  1  downstream ready for peak result
- s_axis_peak_tvalid  output  1  peak result valid, held until accepted
- peak_index  output  index_bits  position in sweep (0-based) of the maximum
- peak_mag  output  mag_bits  unsigned i*i + q*q of the maximum
- overrun  output  1  one-cycle pulse: unaccepted result overwritten

Behaviour:
- Reset (async assert, effective immediately):
  - s_axis_peak_tvalid=0, peak_index=0, peak_mag=0, overrun=0.
  - Sample counter, pipeline valids, running max and running index all cleared.
  - Reset mid-sweep discards the partial sweep; the first valid beat after release is index 0.
- Pipeline: 3 registered stages, fully pipelined; one valid beat per cycle is accepted.
  - S1 registers signed i*i and q*q, each sign-extended into mag_bits, plus the sample index and a last flag.
  - S2 registers their unsigned sum: mag = i*i + q*q. No overflow is possible given the mag_bits constraint.
  - S3 compares mag against the running max:
    - Index 0 of a sweep loads the running max unconditionally.
    - Later indices replace the running max only if strictly greater. On ties the earliest index is kept.
- Sample counter:
  - Increments on each valid input beat.
  - Wraps from sweep_length-1 to 0; the beat at sweep_length-1 is tagged last.
  - Gaps (tvalid low) stall nothing and are simply bubbles.
- Latency and output update:
  - If the last beat of a sweep is accepted at edge E, then at edge E+3 peak_index/peak_mag load the final max (including the last sample) and s_axis_peak_tvalid=1.
  - The running max is reloaded by the next sweep's index 0 in S3, so back-to-back sweeps need no idle cycle.
- Output handshake:
  - A transfer occurs on an edge with s_axis_peak_tvalid & m_axis_peak_tready. That edge clears tvalid unless a new result loads on the same edge; then tvalid stays 1 with the new data.
  - peak_index/peak_mag are stable while tvalid=1 and not accepted.
- Overrun: if a new result loads while tvalid=1 and tready=0:
  - The new result overwrites the old one and tvalid stays 1.
  - overrun=1 for exactly that one cycle.
- Simultaneous events:
  - tready with a new load: the old result is transferred, the new one is presented, and there is no overrun.

Test Plan:
- Basic (i_bits=q_bits=12, mag_bits=25, sweep_length=4, tready=1):
  - Stimulus: (1,0), (3,4), (0,-5), (2,2) on consecutive cycles.
  - Required: tvalid pulses 3 edges after the last beat with peak_index=1, peak_mag=25; this also checks tie-keeps-earliest against index 2.
- Extreme negatives (i_bits=q_bits=12, mag_bits=25, sweep_length=4):
  - Stimulus: (-2048,-2048) at index 3, with the other beats (0,0).
  - Required: peak_index=3, peak_mag=8388608.
- Back-to-back plus bubbles:
  - Stimulus: two sweeps with no idle cycle between them; sweep 2 has 2-cycle tvalid gaps and is (0,1), (0,1), (7,0), (0,1).
  - Required: two results in order; the second is peak_index=2, peak_mag=49 (no leakage from sweep 1).
- Backpressure and overrun:
  - Stimulus: hold tready=0 across two sweep completions.
  - Required: the first result stays stable; when the second loads, overrun pulses 1 cycle and the outputs show the second result. Raising tready then gives one transfer and tvalid drops.
- Reset mid-sweep:
  - Stimulus: assert rst asynchronously (between clock edges) after 2 beats of a sweep, then release.
  - Required: all outputs are 0 immediately. A new full sweep of 4 beats gives one result with indices 0..3, uncontaminated by the pre-reset beats.
